core_fetch_unit: RTL and testbench

- Parametrised successor to the single-register IF stage: decouples PC generation from instruction memory latency.
- Issues word-aligned fetch requests over a valid/ready request channel and accepts in-order responses.
- Buffers {pc, instr} pairs in a FIFO toward decode.
- Supports branch redirect with discard of in-flight stale responses.
- Sits between the core PC logic and the ID stage.

---
 rtl/core_fetch_pkg.sv | 17 +
 rtl/core_fetch_fifo.sv | 53 +++++
 rtl/core_fetch_unit.sv | 123 ++++++++++++
 tb/tb_core_fetch_unit.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_fetch_pkg.sv
// Shared types and constants for the fetch unit: queue entry layout and flush FSM states.
package core_fetch_pkg;

  localparam int FETCH_XLEN  = 32;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [31:0]           instr;
  } fetch_entry_t;

  typedef enum logic {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/core_fetch_fifo.sv
// Synchronous FIFO with flush; flush beats push, and a push into a full FIFO succeeds when paired with a pop.
module core_fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  logic [WIDTH-1:0]           i_wdata,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign o_empty = (count_q == '0);
  assign o_full  = (count_q == CW'(DEPTH));
  assign o_count = count_q;
  assign o_rdata = mem_q[rd_ptr_q];

  assign do_pop  = i_pop && !o_empty;
  assign do_push = i_push && (!o_full || do_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage carries no reset; the empty flag masks stale contents.
  always_ff @(posedge i_clk) begin
    if (do_push && !i_flush) mem_q[wr_ptr_q] <= i_wdata;
  end

endmodule

// File: rtl/core_fetch_unit.sv
// Instruction fetch stage: credit-limited request issue, in-order response capture into a
// fetch queue, and redirect handling that discards responses to stale requests.
module core_fetch_unit
  import core_fetch_pkg::*;
#(
  parameter int              XLEN            = 32,
  parameter logic [XLEN-1:0] RESET_PC        = 'h4000_0000,
  parameter int              FQ_DEPTH        = 4,
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  output logic            o_imem_req_valid,
  input  logic            i_imem_req_ready,
  output logic [XLEN-1:0] o_imem_req_addr,
  input  logic            i_imem_rsp_valid,
  input  logic [31:0]     i_imem_rsp_data,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_id_valid,
  input  logic            i_id_ready,
  output logic [XLEN-1:0] o_id_pc,
  output logic [31:0]     o_id_instr,
  output logic            o_busy
);

  localparam int OW = $clog2(MAX_OUTSTANDING+1);
  localparam int CW = $clog2(FQ_DEPTH+1);
  localparam int EW = XLEN + 32;

  // Handshakes: a transfer happens on any cycle where valid && ready; valid never
  // depends on ready, and responses are accepted unconditionally when valid.

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, rsp_pc_q;
  logic [OW-1:0]   outstanding_q, outstanding_d;
  logic [OW-1:0]   kill_q, kill_d;

  logic            fq_push, fq_pop, fq_full, fq_empty;
  logic [CW-1:0]   fq_count;
  logic [EW-1:0]   fq_wdata, fq_rdata;
  logic [31:0]     occupancy;
  logic            credit_ok, req_fire, rsp_keep;
  logic [XLEN-1:0] redirect_aligned;

  // Every in-flight request already owns a queue slot, so responses can never overflow.
  assign occupancy = 32'(fq_count) + 32'(outstanding_q);
  assign credit_ok = (32'(outstanding_q) < 32'(MAX_OUTSTANDING)) &&
                     (occupancy < 32'(FQ_DEPTH));

  assign o_imem_req_valid = !i_rst && !i_redirect_valid && credit_ok;
  assign o_imem_req_addr  = fetch_pc_q;
  assign req_fire         = o_imem_req_valid && i_imem_req_ready;

  assign redirect_aligned = i_redirect_pc & ~XLEN'(3);
  assign rsp_keep         = i_imem_rsp_valid && (kill_q == '0) && !i_redirect_valid;

  assign o_id_valid = !fq_empty;
  assign fq_pop     = o_id_valid && i_id_ready && !i_redirect_valid;
  assign fq_push    = rsp_keep && (!fq_full || fq_pop);
  assign fq_wdata   = {rsp_pc_q, i_imem_rsp_data};
  assign o_id_pc    = fq_empty ? '0 : fq_rdata[EW-1:32];
  assign o_id_instr = fq_empty ? '0 : fq_rdata[31:0];
  assign o_busy     = (outstanding_q != '0) || (state_q == FLUSH);

  core_fetch_fifo #(
    .DEPTH (FQ_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (fq_push),
    .i_pop   (fq_pop),
    .i_flush (i_redirect_valid),
    .i_wdata (fq_wdata),
    .o_rdata (fq_rdata),
    .o_full  (fq_full),
    .o_empty (fq_empty),
    .o_count (fq_count)
  );

  always_comb begin
    outstanding_d = outstanding_q + OW'(req_fire) - OW'(i_imem_rsp_valid);
    kill_d        = kill_q;
    if (i_redirect_valid) begin
      // Everything still in flight now belongs to the abandoned path.
      kill_d = outstanding_q - OW'(i_imem_rsp_valid);
    end else if (i_imem_rsp_valid && (kill_q != '0)) begin
      kill_d = kill_q - OW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   if (i_redirect_valid && (outstanding_q != '0)) state_d = FLUSH;
      FLUSH:   if (kill_d == '0) state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= FETCH;
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      kill_q        <= '0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      kill_q        <= kill_d;
      if (i_redirect_valid) begin
        fetch_pc_q <= redirect_aligned;
        rsp_pc_q   <= redirect_aligned;
      end else begin
        if (req_fire) fetch_pc_q <= fetch_pc_q + XLEN'(INSTR_BYTES);
        if (rsp_keep) rsp_pc_q   <= rsp_pc_q + XLEN'(INSTR_BYTES);
      end
    end
  end

endmodule

// File: tb/tb_core_fetch_unit.sv
// Bench for core_fetch_unit: in-order memory model with random latency, and a stream-level
// reference that expects sequential PCs from the last reset or redirect target.
module tb_core_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h4000_0000;

  logic        clk;
  logic        i_rst;
  logic        o_imem_req_valid;
  logic        i_imem_req_ready;
  logic [31:0] o_imem_req_addr;
  logic        i_imem_rsp_valid;
  logic [31:0] i_imem_rsp_data;
  logic        i_redirect_valid;
  logic [31:0] i_redirect_pc;
  logic        o_id_valid;
  logic        i_id_ready;
  logic [31:0] o_id_pc;
  logic [31:0] o_id_instr;
  logic        o_busy;

  core_fetch_unit #(
    .XLEN            (32),
    .RESET_PC        (RESET_PC),
    .FQ_DEPTH        (4),
    .MAX_OUTSTANDING (2)
  ) dut (
    .i_clk            (clk),
    .i_rst            (i_rst),
    .o_imem_req_valid (o_imem_req_valid),
    .i_imem_req_ready (i_imem_req_ready),
    .o_imem_req_addr  (o_imem_req_addr),
    .i_imem_rsp_valid (i_imem_rsp_valid),
    .i_imem_rsp_data  (i_imem_rsp_data),
    .i_redirect_valid (i_redirect_valid),
    .i_redirect_pc    (i_redirect_pc),
    .o_id_valid       (o_id_valid),
    .i_id_ready       (i_id_ready),
    .o_id_pc          (o_id_pc),
    .o_id_instr       (o_id_instr),
    .o_busy           (o_busy)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- stimulus knobs and model state ----------------
  int          n_checks, n_errors;
  int          cyc;
  int          ready_pct, id_pct, lat_min, lat_max;
  bit          rst_pend, redir_pend;
  logic [31:0] redir_tgt;

  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          last_due;

  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];
  int          pop_cyc_q[$];
  logic [31:0] exp_pc;
  int          issued, popped, max_infl;
  bit          prev_redir, want_first;
  logic        valid_after_redir;
  logic [31:0] first_req_addr;

  function automatic logic [31:0] mem_fn(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // ---------------- driver: one clock cycle ----------------
  task automatic tick();
    int lat, due;
    @(negedge clk);
    i_rst            = rst_pend;
    rst_pend         = 1'b0;
    i_redirect_valid = redir_pend;
    i_redirect_pc    = redir_tgt;
    redir_pend       = 1'b0;
    i_imem_req_ready = ($urandom_range(0, 99) < ready_pct);
    i_id_ready       = ($urandom_range(0, 99) < id_pct);
    i_imem_rsp_valid = 1'b0;
    i_imem_rsp_data  = '0;
    if (!i_rst && pend_due.size() > 0 && pend_due[0] <= cyc) begin
      i_imem_rsp_valid = 1'b1;
      i_imem_rsp_data  = mem_fn(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    #1;
    if (i_rst) begin
      pend_addr.delete();
      pend_due.delete();
      last_due   = 0;
      exp_pc     = RESET_PC;
      want_first = 1'b1;
    end else begin
      if (prev_redir) valid_after_redir = o_id_valid;
      if (o_id_valid && i_id_ready && !i_redirect_valid) begin
        got_q.push_back({o_id_pc, o_id_instr});
        exp_q.push_back({exp_pc, mem_fn(exp_pc)});
        pop_cyc_q.push_back(cyc);
        exp_pc = exp_pc + 32'd4;
        popped++;
      end
      if (i_redirect_valid) exp_pc = i_redirect_pc & ~32'd3;
      if (o_imem_req_valid && i_imem_req_ready) begin
        if (want_first) first_req_addr = o_imem_req_addr;
        want_first = 1'b0;
        issued++;
        lat = $urandom_range(lat_min, lat_max);
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        pend_addr.push_back(o_imem_req_addr);
        pend_due.push_back(due);
      end
      if (pend_due.size() > max_infl) max_infl = pend_due.size();
    end
    prev_redir = i_redirect_valid && !i_rst;
    cyc++;
  endtask

  task automatic set_knobs(input int rdy, input int idr, input int lmin, input int lmax);
    ready_pct = rdy;
    id_pct    = idr;
    lat_min   = lmin;
    lat_max   = lmax;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    set_knobs(100, 100, 1, 1);
    rst_pend = 1'b1; tick();
    rst_pend = 1'b1; tick();
    n_checks++;
    if (o_imem_req_valid !== 1'b0) begin n_errors++; $display("FAIL reset_req_valid got %b exp 0", o_imem_req_valid); end
    n_checks++;
    if (o_id_valid !== 1'b0) begin n_errors++; $display("FAIL reset_id_valid got %b exp 0", o_id_valid); end
    n_checks++;
    if (o_busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b exp 0", o_busy); end
    n_checks++;
    if (o_id_pc !== 32'h0) begin n_errors++; $display("FAIL reset_id_pc got %h exp 0", o_id_pc); end
    n_checks++;
    if (o_id_instr !== 32'h0) begin n_errors++; $display("FAIL reset_id_instr got %h exp 0", o_id_instr); end
  endtask

  task automatic test_stream();
    int rel_cyc, gaps, n;
    logic [63:0] g, e;
    rel_cyc = cyc;
    for (int i = 0; i < 25; i++) tick();
    n_checks++;
    if (first_req_addr !== RESET_PC) begin n_errors++; $display("FAIL stream_first_addr got %h exp %h", first_req_addr, RESET_PC); end
    n_checks++;
    if (pop_cyc_q.size() < 20) begin
      n_errors++; $display("FAIL stream_count got %0d exp >=20", pop_cyc_q.size());
    end else begin
      n_checks++;
      if (pop_cyc_q[0] != rel_cyc + 2) begin n_errors++; $display("FAIL stream_latency got cycle %0d exp %0d", pop_cyc_q[0], rel_cyc + 2); end
      gaps = 0;
      for (int i = 1; i < pop_cyc_q.size(); i++) if (pop_cyc_q[i] != pop_cyc_q[i-1] + 1) gaps++;
      n_checks++;
      if (gaps != 0) begin n_errors++; $display("FAIL stream_rate got %0d gaps exp 0", gaps); end
    end
    n = 0;
    while (got_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); n_checks++;
      if (g !== e) begin n_errors++; $display("FAIL stream_entry %0d got %h exp %h", n, g, e); end
      n++;
    end
    pop_cyc_q.delete();
  endtask

  task automatic test_backpressure();
    int popped0;
    logic [63:0] g, e;
    set_knobs(100, 0, 1, 1);
    for (int i = 0; i < 20; i++) tick();
    n_checks++;
    if (issued - popped != 4) begin n_errors++; $display("FAIL bp_buffered got %0d exp 4", issued - popped); end
    n_checks++;
    if (pend_due.size() != 0) begin n_errors++; $display("FAIL bp_inflight got %0d exp 0", pend_due.size()); end
    n_checks++;
    if (o_imem_req_valid !== 1'b0) begin n_errors++; $display("FAIL bp_req_valid got %b exp 0", o_imem_req_valid); end
    n_checks++;
    if (o_id_valid !== 1'b1) begin n_errors++; $display("FAIL bp_id_valid got %b exp 1", o_id_valid); end
    id_pct  = 100;
    popped0 = popped;
    for (int i = 0; i < 12; i++) tick();
    n_checks++;
    if (popped - popped0 < 8) begin n_errors++; $display("FAIL bp_release got %0d pops exp >=8", popped - popped0); end
    while (got_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); n_checks++;
      if (g !== e) begin n_errors++; $display("FAIL bp_entry got %h exp %h", g, e); end
    end
    pop_cyc_q.delete();
  endtask

  task automatic test_redirect();
    logic [63:0] g, e;
    bit first;
    set_knobs(100, 100, 3, 3);
    for (int i = 0; i < 20 && pend_due.size() != 2; i++) tick();
    n_checks++;
    if (pend_due.size() != 2) begin n_errors++; $display("FAIL redir_setup got %0d inflight exp 2", pend_due.size()); end
    while (got_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); n_checks++;
      if (g !== e) begin n_errors++; $display("FAIL redir_pre_entry got %h exp %h", g, e); end
    end
    redir_tgt = 32'h4000_0100; redir_pend = 1'b1; valid_after_redir = 1'bx;
    tick();
    tick();
    n_checks++;
    if (valid_after_redir !== 1'b0) begin n_errors++; $display("FAIL redir_id_valid got %b exp 0", valid_after_redir); end
    for (int i = 0; i < 20; i++) tick();
    first = 1'b1;
    n_checks++;
    if (got_q.size() == 0) begin n_errors++; $display("FAIL redir_delivered got 0 exp >0"); end
    while (got_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      if (first) begin
        n_checks++;
        if (g[63:32] !== 32'h4000_0100) begin n_errors++; $display("FAIL redir_first_pc got %h exp 40000100", g[63:32]); end
        first = 1'b0;
      end
      n_checks++;
      if (g !== e) begin n_errors++; $display("FAIL redir_entry got %h exp %h", g, e); end
    end
    ready_pct = 0;
    for (int i = 0; i < 8; i++) tick();
    n_checks++;
    if (o_busy !== 1'b0) begin n_errors++; $display("FAIL redir_busy got %b exp 0", o_busy); end
    pop_cyc_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [63:0] g, e;
    bit first;
    set_knobs(100, 100, 3, 3);
    for (int i = 0; i < 6; i++) tick();
    while (got_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); n_checks++;
      if (g !== e) begin n_errors++; $display("FAIL b2b_pre_entry got %h exp %h", g, e); end
    end
    redir_tgt = 32'h0000_0200; redir_pend = 1'b1; tick();
    redir_tgt = 32'h0000_0300; redir_pend = 1'b1; tick();
    for (int i = 0; i < 30; i++) tick();
    first = 1'b1;
    n_checks++;
    if (got_q.size() < 5) begin n_errors++; $display("FAIL b2b_delivered got %0d exp >=5", got_q.size()); end
    while (got_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      if (first) begin
        n_checks++;
        if (g[63:32] !== 32'h0000_0300) begin n_errors++; $display("FAIL b2b_first_pc got %h exp 00000300", g[63:32]); end
        first = 1'b0;
      end
      n_checks++;
      if (g !== e) begin n_errors++; $display("FAIL b2b_entry got %h exp %h", g, e); end
    end
    n_checks++;
    if (max_infl > 2) begin n_errors++; $display("FAIL b2b_outstanding got %0d exp <=2", max_infl); end
    pop_cyc_q.delete();
  endtask

  task automatic test_random();
    int popped0, bad;
    logic [63:0] g, e;
    set_knobs(60, 60, 1, 5);
    popped0 = popped;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        redir_pend = 1'b1;
        redir_tgt  = $urandom;
      end
      tick();
    end
    set_knobs(100, 100, 1, 1);
    for (int i = 0; i < 20; i++) tick();
    n_checks++;
    if (popped - popped0 < 100) begin n_errors++; $display("FAIL rand_delivered got %0d exp >=100", popped - popped0); end
    bad = 0;
    while (got_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); n_checks++;
      if (g !== e) begin
        n_errors++;
        if (bad < 10) $display("FAIL rand_entry got %h exp %h", g, e);
        bad++;
      end
    end
    n_checks++;
    if (max_infl > 2) begin n_errors++; $display("FAIL rand_outstanding got %0d exp <=2", max_infl); end
    pop_cyc_q.delete();
  endtask

  task automatic test_mid_reset();
    logic [63:0] g, e;
    set_knobs(100, 0, 1, 1);
    for (int i = 0; i < 4; i++) tick();
    n_checks++;
    if (o_id_valid !== 1'b1) begin n_errors++; $display("FAIL mrst_pre_valid got %b exp 1", o_id_valid); end
    while (got_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); n_checks++;
      if (g !== e) begin n_errors++; $display("FAIL mrst_entry got %h exp %h", g, e); end
    end
    rst_pend = 1'b1; tick();
    tick();
    n_checks++;
    if (o_id_valid !== 1'b0) begin n_errors++; $display("FAIL mrst_id_valid got %b exp 0", o_id_valid); end
    n_checks++;
    if (o_busy !== 1'b0) begin n_errors++; $display("FAIL mrst_busy got %b exp 0", o_busy); end
    n_checks++;
    if (first_req_addr !== RESET_PC) begin n_errors++; $display("FAIL mrst_first_addr got %h exp %h", first_req_addr, RESET_PC); end
    id_pct = 100;
    for (int i = 0; i < 10; i++) tick();
    n_checks++;
    if (got_q.size() == 0) begin n_errors++; $display("FAIL mrst_delivered got 0 exp >0"); end
    while (got_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); n_checks++;
      if (g !== e) begin n_errors++; $display("FAIL mrst_post_entry got %h exp %h", g, e); end
    end
    pop_cyc_q.delete();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_checks = 0; n_errors = 0; cyc = 0;
    rst_pend = 1'b0; redir_pend = 1'b0; redir_tgt = '0;
    issued = 0; popped = 0; max_infl = 0; last_due = 0;
    prev_redir = 1'b0; want_first = 1'b0; first_req_addr = '0;
    valid_after_redir = 1'b0; exp_pc = RESET_PC;
    i_rst = 1'b1; i_imem_req_ready = 1'b0; i_imem_rsp_valid = 1'b0;
    i_imem_rsp_data = '0; i_redirect_valid = 1'b0; i_redirect_pc = '0; i_id_ready = 1'b0;
    set_knobs(100, 100, 1, 1);

    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_back_to_back();
    test_random();
    test_mid_reset();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
